operand_fetch: RTL

Pipeline stage directly upstream of the ALU and wrapped around the 32x32 register file. It accepts decoded-format MIPS instructions over a valid/ready handshake and drives the regfile read ports. It presents registered operands downstream and routes writeback results into the regfile write port. It forwards same-cycle writebacks and keeps a 32-entry pending-write scoreboard that stalls RAW and WAW hazards.

---
 rtl/operand_fetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes the source and destination registers, drives the
// regfile ports, forwards same-cycle writebacks, tracks pending writes in a
// scoreboard to stall RAW/WAW hazards, and holds one registered operand bundle.
module operand_fetch (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instr,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        WbValid,
  input  logic [4:0]  WbRegister,
  input  logic [31:0] WbData,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        OpValid,
  input  logic        OpReady,
  output logic [31:0] OpA,
  output logic [31:0] OpB,
  output logic [5:0]  Opcode,
  output logic [4:0]  DestReg,
  output logic [15:0] StallCount
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [4:0]  dest_q, dest_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]  opc;
  logic [4:0]  rs, rt, rd, dest;
  logic        is_r, fwd_a, fwd_b, wb_dest, hazard, accept;
  logic [31:0] src_a, src_b, opnd_b;

  // Regfile write path is a pure pass-through of the writeback port.
  assign WriteRegister = WbRegister;
  assign WriteData     = WbData;
  assign RegWrite      = WbValid && (WbRegister != 5'd0);

  assign ReadRegister1 = Instr[25:21];
  assign ReadRegister2 = Instr[20:16];

  // Decode, forward and select operands for the instruction on the input.
  always_comb begin
    opc    = Instr[31:26];
    rs     = Instr[25:21];
    rt     = Instr[20:16];
    rd     = Instr[15:11];
    is_r   = (opc == 6'd0);
    dest   = is_r ? rd : rt;
    fwd_a  = WbValid && (WbRegister == rs) && (rs != 5'd0);
    fwd_b  = WbValid && (WbRegister == rt) && (rt != 5'd0);
    src_a  = (rs == 5'd0) ? '0 : (fwd_a ? WbData : ReadData1);
    src_b  = (rt == 5'd0) ? '0 : (fwd_b ? WbData : ReadData2);
    opnd_b = is_r ? src_b : {{16{Instr[15]}}, Instr[15:0]};
  end

  // Hazard detection, handshake, scoreboard update and output state machine.
  always_comb begin
    wb_dest = WbValid && (WbRegister == dest);
    hazard  = (pending_q[rs] && !fwd_a)
           || (is_r && pending_q[rt] && !fwd_b)
           || ((dest != 5'd0) && pending_q[dest] && !wb_dest);
    InstrReady = ResetN && ((state_q == EMPTY) || OpReady) && !hazard;
    accept     = InstrValid && InstrReady;

    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    dest_d      = dest_q;
    stall_cnt_d = stall_cnt_q;
    pending_d   = pending_q;

    // Clear before set so an issue to the register being written back wins.
    if (WbValid) pending_d[WbRegister] = 1'b0;
    if (accept && (dest != 5'd0)) pending_d[dest] = 1'b1;
    pending_d[0] = 1'b0;

    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (OpReady && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      op_a_d   = src_a;
      op_b_d   = opnd_b;
      opcode_d = opc;
      dest_d   = dest;
    end

    if (InstrValid && !InstrReady && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q     <= EMPTY;
      pending_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      dest_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      dest_q      <= dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign OpValid    = (state_q == FULL);
  assign OpA        = op_a_q;
  assign OpB        = op_b_q;
  assign Opcode     = opcode_q;
  assign DestReg    = dest_q;
  assign StallCount = stall_cnt_q;

endmodule
